// File: rtl/ofdm_preamble_sequencer.sv
// Transmit preamble sequencer: fires the STF source, then ltf_generator, then passes DATA,
// merging all three phases onto one registered 32-bit IQ stream toward the DAC.
module ofdm_preamble_sequencer #(
  parameter int unsigned STF_LEN       = 160,
  parameter int unsigned LTF_LEN       = 160,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  output logic        stf_go,
  input  logic        stf_valid,
  input  logic [31:0] stf_sample,
  output logic        ltf_letsgo,
  input  logic        ltf_started,
  input  logic [31:0] ltf_sample,
  input  logic        data_valid,
  input  logic [31:0] data_sample,
  input  logic        data_last,
  output logic        data_ready,
  output logic        out_valid,
  output logic [31:0] out_sample,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StStfGo,
    StStfRun,
    StLtfGo,
    StLtfRun,
    StData
  } state_e;

  localparam logic [CNT_W-1:0] StfLast = CNT_W'(STF_LEN - 1);
  localparam logic [CNT_W-1:0] LtfLast = CNT_W'(LTF_LEN - 1);
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(START_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  logic             cap;
  logic             cap_last;
  logic [31:0]      cap_sample;

  logic             out_valid_q, out_last_q;
  logic [31:0]      out_sample_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    cap        = 1'b0;
    cap_last   = 1'b0;
    cap_sample = stf_sample;
    stf_go     = 1'b0;
    ltf_letsgo = 1'b0;
    data_ready = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start) state_d = StStfGo;
      end
      StStfGo: begin
        stf_go  = 1'b1;
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = StStfRun;
      end
      StStfRun: begin
        if (stf_valid) begin
          cap = 1'b1;
          if (cnt_q == StfLast) begin
            cnt_d   = '0;
            state_d = StLtfGo;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == '0) begin
          // Start timeout only applies before the first sample; later gaps are holes.
          if (tmo_q == TmoLast) begin
            err     = 1'b1;
            tmo_d   = '0;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
          end
        end
      end
      StLtfGo: begin
        ltf_letsgo = 1'b1;
        cnt_d      = '0;
        tmo_d      = '0;
        state_d    = StLtfRun;
      end
      StLtfRun: begin
        cap_sample = ltf_sample;
        // Once sample 0 is seen the generator streams contiguously; ltf_started is not rechecked.
        if (cnt_q != '0 || ltf_started) begin
          cap = 1'b1;
          if (cnt_q == LtfLast) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TmoLast) begin
          err     = 1'b1;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      StData: begin
        data_ready = 1'b1;
        cap_sample = data_sample;
        if (data_valid) begin
          cap = 1'b1;
          if (data_last) begin
            cap_last = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tmo_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      out_valid_q <= cap;
      out_last_q  <= cap_last;
      if (cap) out_sample_q <= cap_sample;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_sample = out_sample_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ofdm_preamble_sequencer.sv
// Directed bench for ofdm_preamble_sequencer: per-cycle output scoreboard, scenario sequences,
// and a vector table covering the DATA stall / last-sample boundary.
module tb_ofdm_preamble_sequencer;

  localparam int STF_LEN       = 160;
  localparam int LTF_LEN       = 160;
  localparam int START_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_start, stf_go, stf_valid, ltf_letsgo, ltf_started;
  logic        data_valid, data_last, data_ready, out_valid, out_last, busy, err;
  logic [31:0] stf_sample, ltf_sample, data_sample, out_sample;

  ofdm_preamble_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (tx_start),
    .stf_go     (stf_go),
    .stf_valid  (stf_valid),
    .stf_sample (stf_sample),
    .ltf_letsgo (ltf_letsgo),
    .ltf_started(ltf_started),
    .ltf_sample (ltf_sample),
    .data_valid (data_valid),
    .data_sample(data_sample),
    .data_last  (data_last),
    .data_ready (data_ready),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        dv;
    logic [31:0] ds;
    logic        dl;
    logic        ts;
    logic        ov;
    logic [31:0] os;
    logic        ol;
    logic        rdy;
    logic        bsy;
  } vec_t;

  vec_t        tbl [7];
  logic [32:0] exp_q [int];  // {out_last, out_sample} expected at a given cycle
  int          n_vec = 0, n_fail = 0;
  int          err_at = -1;
  bit          sb_en = 1'b1;
  int          stf_go_n = 0, letsgo_n = 0, err_n = 0, out_n = 0, last_n = 0;

  function automatic logic [31:0] stf_val(input int n);
    return 32'h0001_0000 + 32'(n);
  endfunction

  function automatic logic [31:0] ltf_val(input int n);
    return 32'h4000_0000 + (32'(n) << 16) + 32'(n * 3);
  endfunction

  function automatic logic [31:0] dat_val(input int n);
    return 32'hD000_0000 + 32'(n);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    tx_start    = 1'b0;
    stf_valid   = 1'b0;
    stf_sample  = '0;
    ltf_started = 1'b0;
    ltf_sample  = '0;
    data_valid  = 1'b0;
    data_sample = '0;
    data_last   = 1'b0;
  endtask

  task automatic push(input logic [31:0] s, input logic l);
    exp_q[cyc + 1] = {l, s};
  endtask

  // Mid-cycle observation: pulse counters plus the per-cycle output scoreboard.
  task automatic half();
    @(negedge clk);
    if (stf_go) stf_go_n++;
    if (ltf_letsgo) letsgo_n++;
    if (err) err_n++;
    if (out_valid) out_n++;
    if (out_last) last_n++;
    check1("err", err, (cyc == err_at));
    if (sb_en) begin
      if (exp_q.exists(cyc)) begin
        check1("out_valid", out_valid, 1'b1);
        check32("out_sample", out_sample, exp_q[cyc][31:0]);
        check1("out_last", out_last, exp_q[cyc][32]);
        exp_q.delete(cyc);
      end else begin
        check1("out_valid idle", out_valid, 1'b0);
        check1("out_last idle", out_last, 1'b0);
      end
    end
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    half();
    fin();
  endtask

  task automatic chk_zero(input string tag);
    check1({tag, " out_valid"}, out_valid, 1'b0);
    check32({tag, " out_sample"}, out_sample, 32'h0);
    check1({tag, " out_last"}, out_last, 1'b0);
    check1({tag, " busy"}, busy, 1'b0);
    check1({tag, " stf_go"}, stf_go, 1'b0);
    check1({tag, " ltf_letsgo"}, ltf_letsgo, 1'b0);
    check1({tag, " data_ready"}, data_ready, 1'b0);
    check1({tag, " err"}, err, 1'b0);
  endtask

  // One PPDU. n_data==0 returns in the first DATA cycle; rst_at>=0 resets at that LTF sample.
  task automatic run_ppdu(input int hole0, input int hole1, input bit ltf_ok, input int rst_at,
                          input bit spam, input int n_data);
    int b_go, b_lg, b_err, b_out, b_last, t_go;
    b_go = stf_go_n; b_lg = letsgo_n; b_err = err_n; b_out = out_n; b_last = last_n;
    idle_inputs();
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check1("stf_go after tx_start", stf_go, 1'b1);
    check1("busy after tx_start", busy, 1'b1);
    step();
    step();
    for (int n = 0; n < STF_LEN; n++) begin
      if (n == hole0 || n == hole1) step();
      stf_valid  = 1'b1;
      stf_sample = stf_val(n);
      push(stf_val(n), 1'b0);
      step();
      stf_valid = 1'b0;
    end
    check1("ltf_letsgo after last stf", ltf_letsgo, 1'b1);
    checkn("letsgo before stf end", letsgo_n - b_lg, 0);
    t_go = cyc;
    step();
    if (!ltf_ok) begin
      err_at = t_go + START_TIMEOUT;
      for (int i = 0; i < START_TIMEOUT + 2; i++) step();
      err_at = -1;
      check1("busy after timeout", busy, 1'b0);
      checkn("err pulses", err_n - b_err, 1);
      checkn("stf outputs before timeout", out_n - b_out, STF_LEN);
      return;
    end
    step();
    for (int n = 0; n < LTF_LEN; n++) begin
      ltf_started = (n == 0) || (n == 50);
      ltf_sample  = ltf_val(n);
      if (spam && n == 80) tx_start = 1'b1;
      if (n == rst_at) begin
        #2 reset = 1'b1;
        #1 chk_zero("async reset");
        exp_q.delete();
        idle_inputs();
        half();
        fin();
        reset = 1'b0;
        step();
        step();
        check1("busy after reset release", busy, 1'b0);
        return;
      end
      push(ltf_val(n), 1'b0);
      step();
      tx_start    = 1'b0;
      ltf_started = 1'b0;
    end
    check1("data_ready in DATA", data_ready, 1'b1);
    checkn("stf_go pulses", stf_go_n - b_go, 1);
    checkn("letsgo pulses", letsgo_n - b_lg, 1);
    if (n_data == 0) return;
    for (int n = 0; n < n_data; n++) begin
      data_valid  = 1'b1;
      data_sample = dat_val(n);
      data_last   = (n == n_data - 1);
      if (spam && n == 0) tx_start = 1'b1;
      push(dat_val(n), data_last);
      step();
      tx_start = 1'b0;
    end
    idle_inputs();
    check1("data_ready after last", data_ready, 1'b0);
    check1("busy after last", busy, 1'b0);
    step();
    step();
    checkn("ppdu stf_go pulses", stf_go_n - b_go, 1);
    checkn("ppdu err pulses", err_n - b_err, 0);
    checkn("ppdu outputs", out_n - b_out, STF_LEN + LTF_LEN + n_data);
    checkn("ppdu out_last", last_n - b_last, 1);
  endtask

  initial begin
    tbl[0] = '{1'b1, dat_val(0), 1'b0, 1'b0, 1'b1, ltf_val(LTF_LEN - 1), 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, dat_val(0), 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, dat_val(1), 1'b0, 1'b0, 1'b0, dat_val(0), 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, dat_val(2), 1'b1, 1'b0, 1'b1, dat_val(1), 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, dat_val(2), 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0, dat_val(2), 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, dat_val(2), 1'b0, 1'b0, 1'b0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    reset = 1'b0;
    step();
    step();
    check1("idle busy", busy, 1'b0);

    run_ppdu(-1, -1, 1'b1, -1, 1'b0, 80);   // nominal
    run_ppdu(10, 100, 1'b1, -1, 1'b0, 4);   // STF holes
    run_ppdu(-1, -1, 1'b0, -1, 1'b0, 0);    // LTF start timeout
    run_ppdu(-1, -1, 1'b1, -1, 1'b0, 8);    // full PPDU after timeout
    run_ppdu(-1, -1, 1'b1, -1, 1'b1, 6);    // tx_start ignored while busy
    run_ppdu(-1, -1, 1'b1, 37, 1'b0, 0);    // async reset mid-LTF
    run_ppdu(-1, -1, 1'b1, -1, 1'b0, 5);    // clean PPDU after reset

    // DATA stall and final-sample boundary, vector table
    run_ppdu(-1, -1, 1'b1, -1, 1'b0, 0);
    exp_q.delete();
    sb_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_valid  = tbl[i].dv;
      data_sample = tbl[i].ds;
      data_last   = tbl[i].dl;
      tx_start    = tbl[i].ts;
      half();
      check1($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
      check32($sformatf("row%0d out_sample", i), out_sample, tbl[i].os);
      check1($sformatf("row%0d out_last", i), out_last, tbl[i].ol);
      check1($sformatf("row%0d data_ready", i), data_ready, tbl[i].rdy);
      check1($sformatf("row%0d busy", i), busy, tbl[i].bsy);
      check1($sformatf("row%0d stf_go", i), stf_go, 1'b0);
      fin();
    end
    idle_inputs();
    sb_en = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ofdm_preamble_sequencer.md
Name: ofdm_preamble_sequencer

Overview:
- Transmit-side stage directly downstream of ltf_generator and a sibling STF source.
- Sequences one PPDU: fires the STF source, forwards its samples, fires ltf_generator via its letsgo input, forwards its LTF samples (keyed by LTFstarted), then passes DATA samples from the IFFT path.
- Emits one registered 32-bit IQ stream (I[31:16], Q[15:0]) with valid/last toward the DAC interface.

Parameters:
- STF_LEN, 160, number of STF samples forwarded.
- LTF_LEN, 160, number of LTF samples forwarded.
- START_TIMEOUT, 64, maximum cycles between a start strobe and the first sample of a preamble phase.
- CNT_W, 9, sample/timeout counter width; must hold max(STF_LEN, LTF_LEN, START_TIMEOUT).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- tx_start  in  1  one-cycle request to send one PPDU.
- stf_go  out  1  one-cycle start strobe to the STF source.
- stf_valid  in  1  STF sample qualifier; samples arrive on consecutive cycles.
- stf_sample  in  32  STF IQ sample.
- ltf_letsgo  out  1  one-cycle start strobe to ltf_generator letsgo.
- ltf_started  in  1  ltf_generator LTFstarted; high on the cycle of LTF sample 0.
- ltf_sample  in  32  ltf_generator ltfsequence.
- data_valid  in  1  DATA sample valid.
- data_sample  in  32  DATA IQ sample.
- data_last  in  1  marks the final DATA sample.
- data_ready  out  1  DATA accept; asserted only in the DATA state.
- out_valid  out  1  output sample valid.
- out_sample  out  32  output IQ sample.
- out_last  out  1  high with the final DATA sample.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on start timeout.

Behaviour:
- Reset (async, immediate, including mid-PPDU): state=IDLE; all counters 0; every output 0; out_sample=0.
- States: IDLE, STF_GO, STF_RUN, LTF_GO, LTF_RUN, DATA.
- IDLE: tx_start -> STF_GO. tx_start in any other state is ignored; no queueing.
- STF_GO: stf_go=1 for exactly this cycle; timeout counter cleared; -> STF_RUN.
- STF_RUN before the first sample:
  - Timeout counter increments each cycle without stf_valid.
  - Reaching START_TIMEOUT -> IDLE with err=1 for one cycle.
- STF_RUN sample capture:
  - Each stf_valid cycle captures stf_sample and increments the sample counter.
  - Capture of sample STF_LEN-1 -> LTF_GO.
  - stf_valid low after the first sample: hole, out_valid=0 that cycle, counter holds.
- LTF_GO: ltf_letsgo=1 for one cycle; counters cleared; -> LTF_RUN.
- LTF_RUN start:
  - Waits for ltf_started, with the same timeout and err rule as STF.
  - The ltf_started cycle captures LTF sample 0.
- LTF_RUN continuation:
  - The following LTF_LEN-1 consecutive cycles are captured unconditionally; LTFstarted is not re-checked.
  - After sample LTF_LEN-1 -> DATA.
  - ltf_started re-asserting mid-phase is ignored.
- DATA:
  - data_ready=1.
  - Each data_valid cycle captures data_sample.
  - data_valid&data_last also registers out_last=1 and -> IDLE; data_ready drops the next cycle.
- Output register:
  - Every captured sample appears on out_sample with out_valid=1 exactly one clk later.
  - Latency is exactly 1 cycle.
  - On non-capture cycles out_valid=0 and out_sample holds its last value.
  - out_last is high only with the last DATA sample.
- busy: high from the cycle after tx_start until the cycle after IDLE is re-entered.
- Timing is back-to-back at the phase boundaries: the STF -> LTF gap is exactly 1 (LTF_GO) + generator start latency; the LTF -> DATA boundary has zero idle cycles if data_valid is high.

Test Plan:
- Nominal: tx_start; STF source responds 2 cycles after stf_go with 160 contiguous samples 0x00010000+n; ltf_generator with coefficients=128'd0 -> exactly 160 STF out_valid cycles, one ltf_letsgo pulse, 160 LTF samples equal to ltfsequence delayed 1 cycle, then 80 DATA samples with out_last only on the 80th; err never set; busy falls after the final sample.
- STF holes: stf_valid deasserted at samples 10 and 100 -> out_valid has 2 gaps; STF count is still exactly 160; ltf_letsgo fires only after the 160th sample.
- LTF timeout: ltf_started never asserted -> err pulses once exactly 64 cycles after ltf_letsgo; state=IDLE; busy=0; no out_valid; a new tx_start runs a full PPDU.
- Ignored start: tx_start repeated during LTF_RUN and DATA -> no second stf_go and no count change; the next PPDU starts only on a tx_start after busy=0.
- Async reset mid-LTF (at LTF sample 37): outputs are 0 before the next clk edge; after release an idle bus with no residual out_valid; the next PPDU is correct with 160/160 counts.
- DATA backpressure-free stall: data_valid toggling 1,0,1 with data_last on the 3rd valid -> 3 outputs at the correct 1-cycle latency, out_last on the 3rd, data_ready=0 the cycle after.
